hybrid_switch_sequencer: RTL and testbench

- Sequences the power stage driven by the hybrid-control sigma output.
- Rate-limits the switching-surface angle theta during soft-start and drives it out to the hybrid control block.
- Turns the asynchronous sigma decision into complementary half-bridge gates, with dead time and minimum dwell.
- Latches faults; sits between the hybrid control block and the FPGA gate pins.

---
 rtl/hybrid_switch_sequencer.sv | 166 ++++++++++++++++
 tb/tb_hybrid_switch_sequencer.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/hybrid_switch_sequencer.sv
// hybrid_switch_sequencer: soft-start theta ramp plus dead-time/min-dwell half-bridge gating.
// Define HYBRID_SEQ_SWCOUNT_EN to add the o_n_switch commutation counter.
module hybrid_switch_sequencer #(
  parameter int          DEAD_TIME   = 10,
  parameter int          MIN_DWELL   = 50,
  parameter logic [31:0] THETA_START = 32'd0,
  parameter logic [31:0] THETA_STEP  = 32'd1000,
  parameter int          RAMP_DIV    = 100
) (
  input  logic        i_CLK,
  input  logic        i_RESET,
  input  logic        i_enable,
  input  logic        i_sigma,
  input  logic        i_fault,
  input  logic [31:0] i_theta_target,
  output logic [31:0] o_theta,
  output logic        o_gate_H,
  output logic        o_gate_L,
`ifdef HYBRID_SEQ_SWCOUNT_EN
  output logic [1:0]  o_state,
  output logic [31:0] o_n_switch
`else
  output logic [1:0]  o_state
`endif
);

  localparam int DW  = $clog2(DEAD_TIME + 1);
  localparam int WW  = $clog2(MIN_DWELL + 1);
  localparam int VW  = $clog2(RAMP_DIV + 1);
  localparam logic [DW-1:0] DEAD_LAST = DW'(DEAD_TIME - 1);
  localparam logic [WW-1:0] DWELL_MAX = WW'(MIN_DWELL);
  localparam logic [VW-1:0] DIV_LAST  = VW'(RAMP_DIV - 1);

  typedef enum logic [1:0] {IDLE = 2'd0, RAMP = 2'd1, RUN = 2'd2, FAULT = 2'd3} state_t;
  typedef enum logic {C_DEAD = 1'b0, C_ON = 1'b1} com_t;

  state_t         state, state_nxt;
  com_t           com, com_nxt;
  logic           cur, cur_nxt;
  logic [DW-1:0]  dead_cnt, dead_nxt;
  logic [WW-1:0]  dwell_cnt, dwell_nxt;
  logic [VW-1:0]  div_cnt, div_nxt;
  logic [31:0]    theta_nxt, theta_diff;
  logic           gate_h_nxt, gate_l_nxt;
  logic           sig_m, sig_s;
  logic           active_nxt;

  assign o_state = state;

  always_ff @(posedge i_CLK) begin
    if (!i_RESET) begin
      sig_m     <= 1'b0;
      sig_s     <= 1'b0;
      state     <= IDLE;
      com       <= C_DEAD;
      cur       <= 1'b0;
      dead_cnt  <= '0;
      dwell_cnt <= '0;
      div_cnt   <= '0;
      o_theta   <= THETA_START;
      o_gate_H  <= 1'b0;
      o_gate_L  <= 1'b0;
    end else begin
      sig_m     <= i_sigma;
      sig_s     <= sig_m;
      state     <= state_nxt;
      com       <= com_nxt;
      cur       <= cur_nxt;
      dead_cnt  <= dead_nxt;
      dwell_cnt <= dwell_nxt;
      div_cnt   <= div_nxt;
      o_theta   <= theta_nxt;
      o_gate_H  <= gate_h_nxt;
      o_gate_L  <= gate_l_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    com_nxt    = com;
    cur_nxt    = cur;
    dead_nxt   = dead_cnt;
    dwell_nxt  = dwell_cnt;
    div_nxt    = div_cnt;
    theta_nxt  = o_theta;
    theta_diff = (i_theta_target >= o_theta) ? (i_theta_target - o_theta)
                                             : (o_theta - i_theta_target);
    case (state)
      IDLE: begin
        if (i_enable) begin
          state_nxt = RAMP;
          com_nxt   = C_DEAD;
          dead_nxt  = '0;
          div_nxt   = '0;
        end
      end
      RAMP, RUN: begin
        if (!i_enable) begin
          state_nxt = IDLE;
        end else begin
          // Theta slews one step per divider tick; a small residual snaps to target.
          if (div_cnt == DIV_LAST) begin
            div_nxt = '0;
            if (theta_diff <= THETA_STEP) begin
              theta_nxt = i_theta_target;
              state_nxt = RUN;
            end else if (i_theta_target > o_theta) begin
              theta_nxt = o_theta + THETA_STEP;
            end else begin
              theta_nxt = o_theta - THETA_STEP;
            end
          end else begin
            div_nxt = div_cnt + 1'b1;
          end
          if (com == C_DEAD) begin
            if (dead_cnt == DEAD_LAST) begin
              com_nxt   = C_ON;
              cur_nxt   = sig_s;
              dwell_nxt = '0;
              dead_nxt  = '0;
            end else begin
              dead_nxt = dead_cnt + 1'b1;
            end
          end else begin
            if (dwell_cnt != DWELL_MAX) dwell_nxt = dwell_cnt + 1'b1;
            // A mismatch before dwell expiry is simply re-tested next cycle.
            if ((sig_s != cur) && (dwell_cnt == DWELL_MAX)) begin
              com_nxt  = C_DEAD;
              dead_nxt = '0;
            end
          end
        end
      end
      default: begin
        if (!i_enable) state_nxt = IDLE;
      end
    endcase
    if (i_fault) state_nxt = FAULT;
    if ((state_nxt == IDLE) || (state_nxt == FAULT)) begin
      theta_nxt = THETA_START;
      com_nxt   = C_DEAD;
      cur_nxt   = 1'b0;
      dead_nxt  = '0;
      dwell_nxt = '0;
      div_nxt   = '0;
    end
    active_nxt = (state_nxt == RAMP) || (state_nxt == RUN);
    gate_h_nxt = active_nxt && (com_nxt == C_ON) && cur_nxt;
    gate_l_nxt = active_nxt && (com_nxt == C_ON) && !cur_nxt;
  end

`ifdef HYBRID_SEQ_SWCOUNT_EN
  logic sw_evt;
  assign sw_evt = ((state == RAMP) || (state == RUN)) && (com == C_DEAD) &&
                  (dead_cnt == DEAD_LAST) && (sig_s != cur) && active_nxt;

  always_ff @(posedge i_CLK) begin
    if (!i_RESET || (state_nxt == IDLE)) begin
      o_n_switch <= 32'd0;
    end else if (sw_evt) begin
      o_n_switch <= o_n_switch + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_hybrid_switch_sequencer.sv
// Bench for hybrid_switch_sequencer: timestamp-based reference model checked every cycle,
// plus directed literal checks of ramp timing, dead time, dwell, fault and enable handling.
module tb_hybrid_switch_sequencer;
  localparam int          DEAD_TIME = 10;
  localparam int          MIN_DWELL = 50;
  localparam int          RAMP_DIV  = 100;
  localparam logic [31:0] STEP      = 32'd1000;
  localparam logic [31:0] START     = 32'd0;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0;
  logic        sig = 1'b0;
  logic        flt = 1'b0;
  logic [31:0] tgt = 32'd0;
  logic [31:0] o_theta;
  logic        o_gate_H, o_gate_L;
  logic [1:0]  o_state;
`ifdef HYBRID_SEQ_SWCOUNT_EN
  logic [31:0] o_n_switch;
`endif

  hybrid_switch_sequencer dut (
    .i_CLK          (clk),
    .i_RESET        (rst_n),
    .i_enable       (en),
    .i_sigma        (sig),
    .i_fault        (flt),
    .i_theta_target (tgt),
    .o_theta        (o_theta),
    .o_gate_H       (o_gate_H),
    .o_gate_L       (o_gate_L),
`ifdef HYBRID_SEQ_SWCOUNT_EN
    .o_state        (o_state),
    .o_n_switch     (o_n_switch)
`else
    .o_state        (o_state)
`endif
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference model: mode 0=IDLE 1=RAMP 2=RUN 3=FAULT; timing tracked as edge timestamps.
  int          cyc = 0;
  int          m_mode = 0;
  logic [31:0] m_theta = START;
  bit          m_on = 1'b0, m_cur = 1'b0, m_s1 = 1'b0, m_s2 = 1'b0, m_ss = 1'b0;
  int          m_dead_start = 0, m_on_cyc = 0, m_ramp_cyc = 0;
  logic [31:0] m_cnt = 32'd0;
  logic [31:0] m_diff;
  bit          m_valid = 1'b0;

  task automatic go_inactive(input int mode);
    m_mode  = mode;
    m_theta = START;
    m_on    = 1'b0;
    m_cur   = 1'b0;
    if (mode == 0) m_cnt = 32'd0;
  endtask

  always @(posedge clk) begin
    cyc++;
    m_ss = m_s2;
    if (!rst_n) begin
      m_mode = 0; m_theta = START; m_on = 1'b0; m_cur = 1'b0;
      m_s1 = 1'b0; m_s2 = 1'b0; m_cnt = 32'd0;
    end else begin
      m_s2 = m_s1;
      m_s1 = sig;
      if (flt) go_inactive(3);
      else if (m_mode == 0) begin
        if (en) begin
          m_mode = 1; m_ramp_cyc = cyc; m_dead_start = cyc; m_on = 1'b0;
        end
      end else if (m_mode == 3) begin
        if (!en) go_inactive(0);
      end else if (!en) go_inactive(0);
      else begin
        if (((cyc - m_ramp_cyc) % RAMP_DIV) == 0) begin
          m_diff = (tgt > m_theta) ? tgt - m_theta : m_theta - tgt;
          if (m_diff <= STEP) begin
            m_theta = tgt; m_mode = 2;
          end else if (tgt > m_theta) m_theta = m_theta + STEP;
          else m_theta = m_theta - STEP;
        end
        if (!m_on) begin
          if (cyc - m_dead_start == DEAD_TIME) begin
            if (m_ss != m_cur) m_cnt = m_cnt + 32'd1;
            m_cur = m_ss; m_on = 1'b1; m_on_cyc = cyc;
          end
        end else if ((m_ss != m_cur) && (cyc - 1 - m_on_cyc >= MIN_DWELL)) begin
          m_on = 1'b0; m_dead_start = cyc;
        end
      end
    end
    m_valid = 1'b1;
  end

  always @(negedge clk) begin
    if (m_valid) begin
      chk("state", o_state, m_mode);
      chk("theta", o_theta, m_theta);
      chk("gate_H", o_gate_H, m_on & m_cur);
      chk("gate_L", o_gate_L, m_on & !m_cur);
      chk("overlap", o_gate_H & o_gate_L, 0);
`ifdef HYBRID_SEQ_SWCOUNT_EN
      chk("n_switch", o_n_switch, m_cnt);
`endif
    end
  end

  logic [31:0] t_ref;

  function automatic bit cond(input int which);
    case (which)
      0: return o_state == 2'd2;
      1: return o_gate_L == 1'b0;
      2: return o_gate_H == 1'b1;
      3: return o_gate_H == 1'b0;
      4: return o_gate_L == 1'b1;
      5: return (o_gate_H == 1'b1) || (o_gate_L == 1'b1);
      default: return o_theta != t_ref;
    endcase
  endfunction

  task automatic wait_cond(input int which, input string name, output int n);
    n = 0;
    while (!cond(which) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 2000) chk({name, "_timeout"}, 1, 0);
  endtask

  logic [31:0] exp_th[6] = '{32'd1000, 32'd2000, 32'd3000, 32'd4000, 32'd5000, 32'd5500};

  initial begin
    int n, low;
    int r;
    // Reset and soft-start ramp.
    repeat (3) @(negedge clk);
    chk("rst_state", o_state, 0);
    chk("rst_theta", o_theta, 0);
    chk("rst_gates", {o_gate_H, o_gate_L}, 0);
    rst_n = 1'b1; en = 1'b1; tgt = 32'd5500; sig = 1'b0;
    @(negedge clk);
    chk("ramp_entry", o_state, 1);
    for (int k = 0; k < 6; k++) begin
      t_ref = o_theta;
      wait_cond(6, "ramp_tick", n);
      chk("ramp_interval", n, 100);
      chk("ramp_theta", o_theta, exp_th[k]);
    end
    chk("run_at_tick6", o_state, 2);
    chk("gate_L_on_ramp", o_gate_L, 1);

    // Dead time on a 0->1 commutation after dwell expiry.
    sig = 1'b1;
    wait_cond(1, "l_fall", n);
    chk("sync_latency", n, 3);
    wait_cond(5, "h_rise", n);
    chk("dead_time_len", n, 10);
    chk("h_after_dead", o_gate_H, 1);

    // Minimum dwell: request 20 clocks after turn-on.
    repeat (20) @(negedge clk);
    sig = 1'b0;
    wait_cond(3, "h_fall", n);
    chk("dwell_len", 20 + n, 51);
    wait_cond(4, "l_rise", n);
    chk("dead_time_len2", n, 10);

    // Short glitch inside the dwell window.
    low = 0;
    for (int i = 0; i < 75; i++) begin
      if (i == 10) sig = 1'b1;
      if (i == 15) sig = 1'b0;
      @(negedge clk);
      if (!o_gate_L) low++;
    end
    chk("glitch_no_commute", low, 0);

    // Fault in the middle of dead time.
    sig = 1'b1;
    wait_cond(1, "l_fall2", n);
    chk("sync_latency2", n, 3);
    repeat (3) @(negedge clk);
    flt = 1'b1;
    @(negedge clk);
    chk("fault_gates", {o_gate_H, o_gate_L}, 0);
    chk("fault_state", o_state, 3);
    chk("fault_theta", o_theta, 0);
    flt = 1'b0;
    repeat (5) @(negedge clk);
    chk("fault_hold_en", o_state, 3);
    en = 1'b0;
    @(negedge clk);
    chk("fault_exit", o_state, 0);

    // Enable drop in RUN with gate_H on, then restart.
    tgt = 32'd2500; en = 1'b1;
    wait_cond(0, "run2", n);
    chk("run2_theta", o_theta, 2500);
    chk("run2_gate_H", o_gate_H, 1);
    en = 1'b0;
    @(negedge clk);
    chk("drop_gate_H", o_gate_H, 0);
    chk("drop_state", o_state, 0);
    en = 1'b1;
    @(negedge clk);
    chk("restart_state", o_state, 1);
    chk("restart_theta", o_theta, 0);
    t_ref = o_theta;
    wait_cond(6, "restart_tick", n);
    chk("restart_interval", n, 100);
    chk("restart_theta1", o_theta, 1000);

    // Randomised run; the per-cycle model comparison covers it.
    for (int i = 0; i < 20000; i++) begin
      @(negedge clk);
      r = $urandom_range(0, 9999);
      rst_n = (r != 9999);
      if (!en && r < 100) en = 1'b1;
      else if (r < 2) en = 1'b0;
      if (r >= 2 && r < 4) flt = 1'b1;
      else if (flt && r < 3000) flt = 1'b0;
      if (r >= 10 && r < 14) tgt = $urandom_range(0, 20000);
      if ($urandom_range(0, 39) == 0) sig = ~sig;
    end
    rst_n = 1'b1; flt = 1'b0;
    repeat (5) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
